// File: rtl/fc_l2_port_arbiter.sv
// Round-robin arbiter folding NB_REQ requester ports onto one L2 master port.
// An in-order ID FIFO steers each response back to the requester that issued it.
module fc_l2_port_arbiter #(
  parameter int NB_REQ          = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [NB_REQ-1:0]                       req_i,
  input  logic [NB_REQ-1:0][ADDR_WIDTH-1:0]       add_i,
  input  logic [NB_REQ-1:0]                       wen_i,
  input  logic [NB_REQ-1:0][DATA_WIDTH-1:0]       wdata_i,
  input  logic [NB_REQ-1:0][DATA_WIDTH/8-1:0]     be_i,
  output logic [NB_REQ-1:0]                       gnt_o,
  output logic [NB_REQ-1:0]                       r_valid_o,
  output logic [DATA_WIDTH-1:0]                   r_rdata_o,
  output logic                                    l2_req_o,
  output logic [ADDR_WIDTH-1:0]                   l2_add_o,
  output logic                                    l2_wen_o,
  output logic [DATA_WIDTH-1:0]                   l2_wdata_o,
  output logic [DATA_WIDTH/8-1:0]                 l2_be_o,
  input  logic                                    l2_gnt_i,
  input  logic                                    l2_r_valid_i,
  input  logic [DATA_WIDTH-1:0]                   l2_r_rdata_i,
  output logic                                    err_o
);

  localparam int IDX_W = $clog2(NB_REQ);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];
  logic [IDX_W-1:0] fifo_d [MAX_OUTSTANDING];

  logic [IDX_W-1:0] win_idx;
  logic [IDX_W:0]   cand;
  logic             win_found;
  logic             fifo_full;
  logic             fifo_empty;
  logic             accept;
  logic             pop;
  logic [IDX_W-1:0] head_id;

  // Scan from the priority pointer upward, wrapping at NB_REQ.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NB_REQ)) begin
        cand = cand - (IDX_W+1)'(NB_REQ);
      end
      if (!win_found && req_i[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // The full gate uses the registered count, so a same-cycle pop cannot unblock.
  assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);
  assign l2_req_o   = win_found && !fifo_full && !rst_i;
  assign accept     = l2_req_o && l2_gnt_i;
  assign pop        = l2_r_valid_i && !fifo_empty && !rst_i;
  assign head_id    = fifo_q[rd_ptr_q];

  assign l2_add_o   = add_i[win_idx];
  assign l2_wen_o   = wen_i[win_idx];
  assign l2_wdata_o = wdata_i[win_idx];
  assign l2_be_o    = be_i[win_idx];
  assign r_rdata_o  = l2_r_rdata_i;
  assign err_o      = err_q;

  always_comb begin
    gnt_o     = '0;
    r_valid_o = '0;
    if (accept) begin
      gnt_o[win_idx] = 1'b1;
    end
    if (pop) begin
      r_valid_o[head_id] = 1'b1;
    end
  end

  always_comb begin
    ptr_d    = ptr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    fifo_d   = fifo_q;
    if (accept) begin
      ptr_d            = (win_idx == IDX_W'(NB_REQ-1)) ? '0 : win_idx + IDX_W'(1);
      fifo_d[wr_ptr_q] = win_idx;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // A response with nothing outstanding is a protocol error; it never clears on its own.
    if (l2_r_valid_i && fifo_empty) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      ptr_q    <= ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fc_l2_port_arbiter.sv
// Directed bench for fc_l2_port_arbiter: behavioural round-robin model plus an
// ID scoreboard, with fixed expected values for the key arbitration scenarios.
module tb_fc_l2_port_arbiter;
  localparam int NB = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NB-1:0]          req;
  logic [NB-1:0][AW-1:0]  add;
  logic [NB-1:0]          wen;
  logic [NB-1:0][DW-1:0]  wdata;
  logic [NB-1:0][DW/8-1:0] be;
  logic [NB-1:0]          gnt;
  logic [NB-1:0]          r_valid;
  logic [DW-1:0]          r_rdata;
  logic                   l2_req;
  logic [AW-1:0]          l2_add;
  logic                   l2_wen;
  logic [DW-1:0]          l2_wdata;
  logic [DW/8-1:0]        l2_be;
  logic                   l2_gnt;
  logic                   l2_rv;
  logic [DW-1:0]          l2_rdata;
  logic                   err;

  int n_vec = 0;
  int n_err = 0;
  int sb_q[$];
  int ptr_m = 0;
  bit err_m = 1'b0;

  logic [NB-1:0] obs_gnt, obs_rv;
  logic          obs_req, obs_err;
  logic [DW-1:0] obs_rdata;
  logic [NB-1:0] exp_seq [4];

  always #5 clk = ~clk;

  fc_l2_port_arbiter #(
    .NB_REQ(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt), .r_valid_o(r_valid),
    .r_rdata_o(r_rdata), .l2_req_o(l2_req), .l2_add_o(l2_add), .l2_wen_o(l2_wen),
    .l2_wdata_o(l2_wdata), .l2_be_o(l2_be), .l2_gnt_i(l2_gnt),
    .l2_r_valid_i(l2_rv), .l2_r_rdata_i(l2_rdata), .err_o(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [NB-1:0] rq, input logic g,
                       input logic rv, input logic [DW-1:0] rd);
    rst = r; req = rq; l2_gnt = g; l2_rv = rv; l2_rdata = rd;
    for (int k = 0; k < NB; k++) begin
      add[k]   = $urandom;
      wdata[k] = $urandom;
      wen[k]   = 1'($urandom_range(0, 1));
      be[k]    = 4'($urandom_range(0, 15));
    end
  endtask

  // Check one cycle against the model at the falling edge, then advance the model.
  task automatic cycle(input string tag);
    int win;
    bit acc, pop, empty0;
    logic e_req;
    logic [NB-1:0] e_gnt, e_rv;
    @(negedge clk);
    win = -1;
    for (int i = 0; i < NB; i++) begin
      if (win < 0 && req[(ptr_m + i) % NB]) win = (ptr_m + i) % NB;
    end
    empty0 = (sb_q.size() == 0);
    e_req  = !rst && (win >= 0) && (sb_q.size() < MO);
    acc    = e_req && l2_gnt;
    pop    = !rst && l2_rv && !empty0;
    e_gnt  = acc ? NB'(1 << win) : '0;
    e_rv   = pop ? NB'(1 << sb_q[0]) : '0;
    obs_gnt = gnt; obs_rv = r_valid; obs_req = l2_req; obs_err = err; obs_rdata = r_rdata;
    chk({tag, "_l2req"}, l2_req, e_req);
    chk({tag, "_gnt"}, gnt, e_gnt);
    chk({tag, "_rvalid"}, r_valid, e_rv);
    chk({tag, "_err"}, err, err_m);
    if (e_req) begin
      chk({tag, "_add"}, l2_add, add[win]);
      chk({tag, "_wen"}, l2_wen, wen[win]);
      chk({tag, "_wdata"}, l2_wdata, wdata[win]);
      chk({tag, "_be"}, l2_be, be[win]);
    end
    if (pop) chk({tag, "_rdata"}, r_rdata, l2_rdata);
    if (rst) begin
      sb_q.delete();
      ptr_m = 0;
      err_m = 1'b0;
    end else begin
      if (pop) void'(sb_q.pop_front());
      if (acc) begin
        sb_q.push_back(win);
        ptr_m = (win + 1) % NB;
      end
      if (l2_rv && empty0) err_m = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b1, 2'b11, 1'b1, 1'b1, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    cycle("rst");
    chk("rst_err", obs_err, 1'b0);

    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 2'b11, 1'b1, 1'b0, 32'h0);
      cycle("rr");
      chk("rr_gnt_seq", obs_gnt, exp_seq[k]);
    end

    drive(1'b0, 2'b11, 1'b1, 1'b0, 32'h0);
    cycle("full");
    chk("full_l2req", obs_req, 1'b0);
    chk("full_gnt", obs_gnt, 2'b00);
    drive(1'b0, 2'b11, 1'b1, 1'b1, 32'h1111_0000);
    cycle("fullpop");
    chk("fullpop_l2req", obs_req, 1'b0);
    chk("fullpop_rv", obs_rv, 2'b01);
    drive(1'b0, 2'b11, 1'b1, 1'b0, 32'h0);
    cycle("refill");
    chk("refill_gnt", obs_gnt, 2'b01);

    exp_seq = '{2'b10, 2'b01, 2'b10, 2'b01};
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 2'b00, 1'b0, 1'b1, 32'hD000_0000 + 32'(k));
      cycle("drain");
      chk("drain_rv_seq", obs_rv, exp_seq[k]);
    end

    drive(1'b0, 2'b01, 1'b0, 1'b0, 32'h0);
    cycle("drop");
    chk("drop_gnt", obs_gnt, 2'b00);
    drive(1'b0, 2'b10, 1'b1, 1'b0, 32'h0);
    cycle("t");
    chk("t_gnt", obs_gnt, 2'b10);
    drive(1'b0, 2'b00, 1'b0, 1'b1, 32'hCAFE_F00D);
    cycle("t1");
    chk("t1_rv", obs_rv, 2'b10);
    chk("t1_rdata", obs_rdata, 32'hCAFE_F00D);

    drive(1'b0, 2'b10, 1'b1, 1'b0, 32'h0);
    cycle("fill_a");
    drive(1'b0, 2'b01, 1'b1, 1'b0, 32'h0);
    cycle("fill_b");
    drive(1'b0, 2'b11, 1'b1, 1'b1, 32'h5555_AAAA);
    cycle("simul");
    chk("simul_gnt", obs_gnt, 2'b10);
    chk("simul_rv_oldest", obs_rv, 2'b10);
    exp_seq = '{2'b01, 2'b10, 2'b00, 2'b00};
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 2'b00, 1'b0, 1'b1, 32'hE000_0000 + 32'(k));
      cycle("cnt2");
      chk("cnt2_rv_seq", obs_rv, exp_seq[k]);
    end

    drive(1'b0, 2'b11, 1'b1, 1'b0, 32'h0);
    cycle("pre_a");
    drive(1'b0, 2'b11, 1'b1, 1'b0, 32'h0);
    cycle("pre_b");
    drive(1'b0, 2'b01, 1'b1, 1'b0, 32'h0);
    cycle("pre_c");
    drive(1'b1, 2'b11, 1'b1, 1'b1, 32'h0);
    cycle("rst2");
    chk("rst2_l2req", obs_req, 1'b0);
    chk("rst2_rv", obs_rv, 2'b00);
    drive(1'b0, 2'b11, 1'b1, 1'b0, 32'h0);
    cycle("post");
    chk("post_gnt", obs_gnt, 2'b01);
    chk("post_err", obs_err, 1'b0);

    drive(1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
    cycle("rst3");
    drive(1'b0, 2'b00, 1'b0, 1'b1, 32'hBEEF_0001);
    cycle("orphan");
    chk("orphan_rv", obs_rv, 2'b00);
    chk("orphan_err_now", obs_err, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
      cycle("sticky");
      chk("sticky_err", obs_err, 1'b1);
    end
    drive(1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
    cycle("rst4");
    drive(1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
    cycle("clr");
    chk("clr_err", obs_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
